// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared CPU pipeline definitions: operand-forward select encodings and shadow entries.
// Pure declarations and combinational helpers; no state.
// Used by the hazard/forwarding controller and its sub-blocks.
package hazard_fwd_ctrl_pkg;

    // Operand mux select encodings (rs and rt muxes use the same map)
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    // Shadow copy of one downstream pipeline stage, as seen by the hazard logic
    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       wen;
        logic       load;
    } shadow_t;

    localparam shadow_t SHADOW_BUBBLE = '0;

    // A stage produces a source operand only if it really writes that non-zero register
    function automatic logic src_match(input shadow_t e, input logic [4:0] src,
                                       input logic used);
        return used && e.valid && e.wen && (e.dest == src) && (src != 5'd0);
    endfunction

    // Youngest producer wins: EX, then MEM, then WB, else the register file
    function automatic logic [1:0] fwd_select(input shadow_t ex, input shadow_t mem,
                                              input shadow_t wb, input logic [4:0] src,
                                              input logic used);
        if (src_match(ex, src, used))       return FWD_EX;
        else if (src_match(mem, src, used)) return FWD_MEM;
        else if (src_match(wb, src, used))  return FWD_WB;
        else                                return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_md_busy_cnt.sv
// Mul/div occupancy counter: loads LAT-1 when a mul/div enters EX, counts down to zero.
// Busy flag is registered state (no combinational path from load_i).
// No backpressure: a load while busy is never issued by the controller.
module md_busy_cnt
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int unsigned LAT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic busy_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Next count: reload on a new mul/div, otherwise drain towards idle
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = 4'(LAT - 1);
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Counter register; reset abandons any mul/div in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != 4'd0);

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and operand-forwarding control for a 5-stage pipeline with multi-cycle mul/div.
// Selects are combinational from ID inputs and shadow state; shadow entries update every cycle.
// Stalls IF/ID for one cycle on load-use, and for MD_LAT-1 cycles while a mul/div occupies EX.
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int unsigned MD_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_rs_used,
    input  logic       id_rt_used,
    input  logic [4:0] id_rd,
    input  logic       id_wen,
    input  logic       id_is_load,
    input  logic       id_is_md,
    input  logic       flush,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel,
    output logic       stall,
    output logic       bubble
);

    shadow_t ex_q, mem_q, wb_q;
    shadow_t ex_d, mem_d, wb_d;
    shadow_t id_entry;
    logic    md_busy;
    logic    load_use;
    logic    id_enters;
    logic    md_load;

    // A killed or absent ID instruction can never cause a load-use stall
    assign load_use = id_valid && !flush && ex_q.load &&
                      (src_match(ex_q, id_rs, id_rs_used) || src_match(ex_q, id_rt, id_rt_used));

    assign stall  = load_use || md_busy;
    assign bubble = load_use && !md_busy;

    assign fwd_a_sel = fwd_select(ex_q, mem_q, wb_q, id_rs, id_rs_used);
    assign fwd_b_sel = fwd_select(ex_q, mem_q, wb_q, id_rt, id_rt_used);

    // Flush has no effect while busy: EX is frozen and the branch unit holds flush until stall drops
    assign id_enters = id_valid && !flush && !load_use && !md_busy;
    assign md_load   = id_enters && id_is_md;

    assign id_entry = '{valid: 1'b1, dest: id_rd, wen: id_wen, load: id_is_load};

    md_busy_cnt #(
        .LAT (MD_LAT)
    ) u_md_busy_cnt (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (md_load),
        .busy_o (md_busy)
    );

    // Shadow pipeline advance; a busy mul/div freezes EX and feeds bubbles into MEM
    always_comb begin
        ex_d  = ex_q;
        mem_d = SHADOW_BUBBLE;
        wb_d  = mem_q;
        if (!md_busy) begin
            ex_d  = id_enters ? id_entry : SHADOW_BUBBLE;
            mem_d = ex_q;
        end
    end

    // Shadow entry registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= SHADOW_BUBBLE;
            mem_q <= SHADOW_BUBBLE;
            wb_q  <= SHADOW_BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed-vector bench for hazard_fwd_ctrl; expected outputs are queued per cycle
// and a negedge monitor pops and compares them against the DUT.
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_rs_used, id_rt_used, id_wen, id_is_load, id_is_md, flush;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall, bubble;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.MD_LAT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_used (id_rs_used),
        .id_rt_used (id_rt_used),
        .id_rd      (id_rd),
        .id_wen     (id_wen),
        .id_is_load (id_is_load),
        .id_is_md   (id_is_md),
        .flush      (flush),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel),
        .stall      (stall),
        .bubble     (bubble)
    );

    typedef struct {
        string      name;
        logic [1:0] a;
        logic [1:0] b;
        logic       st;
        logic       bb;
        logic       care_a;
        logic       care_b;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Monitor: one expectation per cycle, compared away from the active edge
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            logic bad;
            e = exp_q.pop_front();
            n_vec++;
            bad = (stall !== e.st) || (bubble !== e.bb) ||
                  (e.care_a && (fwd_a_sel !== e.a)) || (e.care_b && (fwd_b_sel !== e.b));
            if (bad) begin
                n_fail++;
                $display("FAIL %s: got a=%b b=%b stall=%b bubble=%b, want a=%b%s b=%b%s stall=%b bubble=%b",
                         e.name, fwd_a_sel, fwd_b_sel, stall, bubble,
                         e.a, e.care_a ? "" : "(dc)", e.b, e.care_b ? "" : "(dc)", e.st, e.bb);
            end
        end
    end

    task automatic drive(input logic v, input logic [4:0] rs, input logic rsu,
                         input logic [4:0] rt, input logic rtu, input logic [4:0] rd,
                         input logic wen, input logic ld, input logic md,
                         input logic fl, input logic r);
        id_valid   = v;
        id_rs      = rs;
        id_rs_used = rsu;
        id_rt      = rt;
        id_rt_used = rtu;
        id_rd      = rd;
        id_wen     = wen;
        id_is_load = ld;
        id_is_md   = md;
        flush      = fl;
        rst        = r;
    endtask

    task automatic expect_out(input string nm, input logic [1:0] a, input logic ca,
                              input logic [1:0] b, input logic cb,
                              input logic st, input logic bb);
        exp_t e;
        e.name = nm; e.a = a; e.b = b; e.st = st; e.bb = bb; e.care_a = ca; e.care_b = cb;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        // Reset state after first edge
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        expect_out("reset_state", 2'b00, 1, 2'b00, 1, 0, 0); tick();
        // Nothing in flight: reads come from the register file
        drive(1, 3, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        expect_out("empty_pipe", 2'b00, 1, 2'b00, 1, 0, 0); tick();
        // add $3 enters EX
        drive(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0);
        expect_out("add3_issue", 2'b00, 1, 2'b00, 1, 0, 0); tick();
        drive(1, 3, 1, 4, 1, 6, 1, 0, 0, 0, 0);
        expect_out("fwd_ex_rs3", 2'b01, 1, 2'b00, 1, 0, 0); tick();
        drive(1, 3, 1, 6, 1, 0, 0, 0, 0, 0, 0);
        expect_out("fwd_mem_ex", 2'b10, 1, 2'b01, 1, 0, 0); tick();
        drive(1, 3, 1, 6, 1, 5, 1, 0, 0, 0, 0);
        expect_out("fwd_wb_mem", 2'b11, 1, 2'b10, 1, 0, 0); tick();
        // Second writer of $5; reading $0 never forwards
        drive(1, 0, 1, 0, 1, 5, 1, 0, 0, 0, 0);
        expect_out("reg0_rf", 2'b00, 1, 2'b00, 1, 0, 0); tick();
        drive(1, 7, 1, 7, 1, 7, 0, 0, 0, 0, 0);
        expect_out("no_match_7", 2'b00, 1, 2'b00, 1, 0, 0); tick();
        // $5 in both MEM and WB: MEM wins; unused rs ignores the match
        drive(1, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        expect_out("mem_over_wb", 2'b00, 1, 2'b10, 1, 0, 0); tick();
        // lw $8 then dependent read
        drive(1, 1, 1, 1, 1, 8, 1, 1, 0, 0, 0);
        expect_out("lw8_issue", 2'b00, 1, 2'b00, 1, 0, 0); tick();
        drive(1, 8, 1, 2, 1, 9, 1, 0, 0, 0, 0);
        expect_out("load_use", 2'b00, 0, 2'b00, 1, 1, 1); tick();
        drive(1, 8, 1, 2, 1, 9, 1, 0, 0, 0, 0);
        expect_out("load_use_after", 2'b10, 1, 2'b00, 1, 0, 0); tick();
        // lw $10, then dependent read killed by flush
        drive(1, 0, 1, 0, 1, 10, 1, 1, 0, 0, 0);
        expect_out("lw10_issue", 2'b00, 1, 2'b00, 1, 0, 0); tick();
        drive(1, 10, 1, 0, 1, 11, 1, 0, 0, 1, 0);
        expect_out("flush_no_stall", 2'b00, 0, 2'b00, 1, 0, 0); tick();
        drive(1, 11, 1, 10, 1, 0, 0, 0, 0, 0, 0);
        expect_out("flush_bubble_ex", 2'b00, 1, 2'b10, 1, 0, 0); tick();
        // Invalid ID never stalls even with a load match
        drive(1, 0, 1, 0, 1, 12, 1, 1, 0, 0, 0);
        expect_out("lw12_issue", 2'b00, 1, 2'b00, 1, 0, 0); tick();
        drive(0, 12, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        expect_out("invalid_no_stall", 2'b00, 0, 2'b00, 1, 0, 0); tick();
        // mult writing $0 with MD_LAT=4
        drive(1, 12, 1, 1, 1, 0, 1, 0, 1, 0, 0);
        expect_out("mult_issue", 2'b10, 1, 2'b00, 1, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 0, 1, 13, 1, 0, 0, 0, 0);
            expect_out("md_busy", 2'b00, 1, 2'b00, 1, 1, 0); tick();
        end
        drive(1, 0, 1, 0, 1, 13, 1, 0, 0, 0, 0);
        expect_out("md_done_r0", 2'b00, 1, 2'b00, 1, 0, 0); tick();
        drive(1, 13, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        expect_out("ex_advanced", 2'b01, 1, 2'b00, 1, 0, 0); tick();
        // Reset on second busy cycle of a mul/div
        drive(1, 13, 1, 0, 1, 14, 1, 0, 1, 0, 0);
        expect_out("mult14_issue", 2'b10, 1, 2'b00, 1, 0, 0); tick();
        drive(1, 14, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        expect_out("md14_busy1", 2'b00, 0, 2'b00, 1, 1, 0); tick();
        drive(1, 14, 1, 0, 1, 0, 0, 0, 0, 0, 1);
        expect_out("md14_busy2_rst", 2'b00, 0, 2'b00, 1, 1, 0); tick();
        drive(1, 14, 1, 13, 1, 0, 0, 0, 0, 0, 0);
        expect_out("post_rst_md", 2'b00, 1, 2'b00, 1, 0, 0); tick();
        // Reset during a pending load-use
        drive(1, 0, 1, 0, 1, 15, 1, 1, 0, 0, 0);
        expect_out("lw15_issue", 2'b00, 1, 2'b00, 1, 0, 0); tick();
        drive(1, 15, 1, 0, 1, 0, 0, 0, 0, 0, 1);
        expect_out("load_use_rst", 2'b00, 0, 2'b00, 1, 1, 1); tick();
        drive(1, 15, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        expect_out("post_rst_lu", 2'b00, 1, 2'b00, 1, 0, 0); tick();

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 SHALL have parameter: MD_LAT, 4, total EX-stage cycles of a mul/div instruction (legal range 2..15).
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: id_valid  input  1  ID stage holds a real instruction.
REQ-005 SHALL have ports: id_rs / id_rt  input  5 each  ID source register numbers.
REQ-006 SHALL have ports: id_rs_used / id_rt_used  input  1 each  source actually read.
REQ-007 SHALL have port: id_rd  input  5  ID destination register, already selected.
REQ-008 SHALL have port: id_wen  input  1  ID instruction writes the register file.
REQ-009 SHALL have port: id_is_load  input  1  ID instruction is a load.
REQ-010 SHALL have port: id_is_md  input  1  ID instruction is a multi-cycle mul/div.
REQ-011 SHALL have port: flush  input  1  taken branch; kill the ID instruction.
REQ-012 SHALL have ports: fwd_a_sel / fwd_b_sel  output  2 each  selects for the rs/rt 4:1 32-bit operand muxes.
REQ-013 SHALL have port: stall  output  1  freeze PC and IF/ID.
REQ-014 SHALL have port: bubble  output  1  load NOP into ID/EX.

Function
REQ-015 SHALL keep three registered shadow entries, EX, MEM and WB, each holding {valid, dest, wen, load}.
REQ-016 SHALL advance the entries every cycle when md_busy=0: EX<=ID (or a bubble), MEM<=EX, WB<=MEM.
REQ-017 SHALL load a bubble into EX when stall=1 or flush=1 or id_valid=0.
REQ-018 SHALL use select encoding 00 regfile, 01 EX result, 10 MEM result (including load data), 11 WB result.
REQ-019 SHALL match a source only if it is used, its entry is valid, wen=1 and dest equals the source with dest!=0; register 0 always selects 00.
REQ-020 SHALL give priority EX > MEM > WB when several entries match; the selects are combinational.
REQ-021 SHALL raise a load-use stall for exactly one cycle when the EX entry is a load and matches a used source; during that cycle the select for that source is don't-care.
REQ-022 SHALL load md_cnt with MD_LAT-1 when an md instruction enters EX.
REQ-023 SHALL treat md_busy as (md_cnt!=0): while busy, EX holds, MEM receives a bubble, WB advances, md_cnt decrements, and stall=1.
REQ-024 SHALL assert stall as load_use OR md_busy, and SHALL assert bubble as load_use AND NOT md_busy.
REQ-025 SHALL let flush override load_use, so a killed instruction causes no stall.
REQ-026 SHALL ignore flush while md_busy=1; the branch unit holds flush until stall falls.
REQ-027 SHALL not stall when id_valid=0, regardless of matches.

Reset
REQ-028 SHALL, with rst=1 at a clock edge, clear all entry valid bits, set md_cnt=0, and drive fwd_a_sel=fwd_b_sel=00, stall=0, bubble=0 from the next cycle.
REQ-029 SHALL abandon a mid-flight md stall or a pending load-use stall on reset, with no residual stall afterwards.

Structure
REQ-030 SHALL place the FWD_RF/FWD_EX/FWD_MEM/FWD_WB encodings and the shadow-entry typedef in the shared CPU package.
REQ-031 SHALL implement the mul/div counter as sub-module md_busy_cnt (load, decrement, busy flag).

Verification
REQ-032 SHALL cover: add $3 in EX, then ID reads rs=$3 -> fwd_a_sel=01, stall=0.
REQ-033 SHALL cover: writes to $5 in both MEM and WB, then ID reads rt=$5 -> fwd_b_sel=10 (MEM wins).
REQ-034 SHALL cover: lw $8 in EX, then ID reads rs=$8 -> one cycle stall=1, bubble=1; next cycle fwd_a_sel=10, stall=0.
REQ-035 SHALL cover: mult issued with MD_LAT=4 -> stall=1 for 3 cycles, then EX advances; a dependent read of $0 gives select 00.
REQ-036 SHALL cover: load-use with flush=1 in the same cycle -> stall=0 and a bubble enters EX.
REQ-037 SHALL cover: rst=1 on the second md-busy cycle -> next cycle stall=0, all selects 00.
